tx_arbiter: RTL and testbench

//  Shares one serial transmitter (tx) between two byte requesters. Arbitrates

---
 rtl/tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between two byte requesters.
// All outputs are registered; next-cycle values are computed combinationally from the next state.
//
// state   | meaning
// S_IDLE  | no frame in flight, arbitrating between requesters
// S_START | tx_start asserted, waiting for tx_busy (timeout down-counter running)
// S_BUSY  | transmitter busy with the latched byte
// S_GAP   | inter-frame gap down-counter running, requests ignored
module tx_arbiter #(
  parameter int GAP_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             tx_start,
  output logic [7:0]       tx_pi,
  input  logic             tx_busy,
  output logic             grant,
  output logic             arb_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sent0_cnt,
  output logic [CNT_W-1:0] sent1_cnt
);

  localparam int TMR_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic               last_win, last_win_nxt;
  logic               pick1;
  logic               req0_ready_nxt, req1_ready_nxt;
  logic               tx_start_nxt, timeout_err_nxt, arb_busy_nxt;
  logic [7:0]         tx_pi_nxt;
  logic               grant_nxt;
  logic [CNT_W-1:0]   sent0_nxt, sent1_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tmr         <= '0;
      last_win    <= 1'b1;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      tx_start    <= 1'b0;
      tx_pi       <= 8'h00;
      grant       <= 1'b0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
      sent0_cnt   <= '0;
      sent1_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      last_win    <= last_win_nxt;
      req0_ready  <= req0_ready_nxt;
      req1_ready  <= req1_ready_nxt;
      tx_start    <= tx_start_nxt;
      tx_pi       <= tx_pi_nxt;
      grant       <= grant_nxt;
      arb_busy    <= arb_busy_nxt;
      timeout_err <= timeout_err_nxt;
      sent0_cnt   <= sent0_nxt;
      sent1_cnt   <= sent1_nxt;
    end
  end

  // On a tie the requester that did not win last time takes the grant.
  assign pick1 = req1_valid && (!req0_valid || !last_win);

  always_comb begin
    state_nxt       = state;
    tmr_nxt         = tmr;
    last_win_nxt    = last_win;
    req0_ready_nxt  = 1'b0;
    req1_ready_nxt  = 1'b0;
    tx_start_nxt    = 1'b0;
    timeout_err_nxt = 1'b0;
    tx_pi_nxt       = tx_pi;
    grant_nxt       = grant;
    sent0_nxt       = sent0_cnt;
    sent1_nxt       = sent1_cnt;

    case (state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt      = S_START;
          tmr_nxt        = START_LOAD;
          tx_start_nxt   = 1'b1;
          last_win_nxt   = pick1;
          grant_nxt      = pick1;
          tx_pi_nxt      = pick1 ? req1_data : req0_data;
          req0_ready_nxt = !pick1;
          req1_ready_nxt = pick1;
        end
      end
      S_START: begin
        // Busy already high on the first START cycle counts as seen.
        if (tx_busy) begin
          state_nxt = S_BUSY;
        end else if (tmr == '0) begin
          state_nxt       = S_IDLE;
          timeout_err_nxt = 1'b1;
        end else begin
          tmr_nxt      = tmr - TMR_W'(1);
          tx_start_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (!tx_busy) begin
          if (grant) sent1_nxt = sent1_cnt + CNT_W'(1);
          else       sent0_nxt = sent0_cnt + CNT_W'(1);
          if (HAS_GAP) begin
            state_nxt = S_GAP;
            tmr_nxt   = GAP_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (tmr == '0) state_nxt = S_IDLE;
        else           tmr_nxt   = tmr - TMR_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    arb_busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Testbench for tx_arbiter: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based model of grants, gaps, timeouts and frame counts.
module tb_tx_arbiter;

  localparam int GAP_CYCLES   = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int CNT_W        = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             tx_start, tx_busy;
  logic [7:0]       tx_pi;
  logic             grant, arb_busy, timeout_err;
  logic [CNT_W-1:0] sent0_cnt, sent1_cnt;

  always #5 clk = ~clk;

  tx_arbiter #(
    .GAP_CYCLES  (GAP_CYCLES),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_pi      (tx_pi),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err),
    .sent0_cnt  (sent0_cnt),
    .sent1_cnt  (sent1_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transmitter behaviour knobs, written only by the main sequence.
  int cfg_delay = 3;
  int cfg_len   = 4;
  bit rand_mode = 1'b0;

  // Reference model: frame bookkeeping by edge timestamps.
  int         cyc;
  bit         m_in_frame, m_wait_busy, m_last, m_grant;
  bit         m_r0, m_r1, m_to;
  int         m_start_edge, m_free_edge;
  logic [7:0] m_pi;
  int         m_sent0, m_sent1;

  task automatic model_reset();
    m_in_frame  = 1'b0;
    m_wait_busy = 1'b0;
    m_free_edge = 0;
    m_last      = 1'b1;
    m_grant     = 1'b0;
    m_pi        = 8'h00;
    m_sent0     = 0;
    m_sent1     = 0;
    m_r0        = 1'b0;
    m_r1        = 1'b0;
    m_to        = 1'b0;
  endtask

  task automatic model_step(input bit v0, input bit v1, input logic [7:0] d0,
                            input logic [7:0] d1, input bit busy);
    bit w;
    m_r0 = 1'b0;
    m_r1 = 1'b0;
    m_to = 1'b0;
    if (!m_in_frame) begin
      if (cyc >= m_free_edge && (v0 || v1)) begin
        w            = (v0 && v1) ? !m_last : v1;
        m_last       = w;
        m_grant      = w;
        m_pi         = w ? d1 : d0;
        m_r0         = !w;
        m_r1         = w;
        m_in_frame   = 1'b1;
        m_wait_busy  = 1'b1;
        m_start_edge = cyc;
      end
    end else if (m_wait_busy) begin
      if (busy) begin
        m_wait_busy = 1'b0;
      end else if (cyc - m_start_edge == BUSY_TIMEOUT) begin
        m_to        = 1'b1;
        m_in_frame  = 1'b0;
        m_wait_busy = 1'b0;
        m_free_edge = cyc + 1;
      end
    end else if (!busy) begin
      if (m_grant) m_sent1++;
      else         m_sent0++;
      m_in_frame  = 1'b0;
      m_free_edge = cyc + GAP_CYCLES + 1;
    end
  endtask

  initial begin : monitor
    bit         v0s, v1s, bs;
    logic [7:0] d0s, d1s;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      v0s = req0_valid;
      v1s = req1_valid;
      d0s = req0_data;
      d1s = req1_data;
      bs  = tx_busy;
      if (rst) model_reset();
      else     model_step(v0s, v1s, d0s, d1s, bs);
      #1;
      check("req0_ready",  32'(req0_ready),  32'(m_r0));
      check("req1_ready",  32'(req1_ready),  32'(m_r1));
      check("tx_start",    32'(tx_start),    32'(m_in_frame && m_wait_busy));
      check("tx_pi",       32'(tx_pi),       32'(m_pi));
      check("grant",       32'(grant),       32'(m_grant));
      check("arb_busy",    32'(arb_busy),    32'(m_in_frame || (cyc + 1 < m_free_edge)));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
      check("sent0_cnt",   32'(sent0_cnt),   32'(m_sent0 % (1 << CNT_W)));
      check("sent1_cnt",   32'(sent1_cnt),   32'(m_sent1 % (1 << CNT_W)));
    end
  end

  // Transmitter stand-in: raises busy a delay after seeing tx_start, holds it for a length.
  initial begin : tx_model
    int ph, cnt, d, l;
    ph      = 0;
    cnt     = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        ph      = 0;
      end else if (ph == 0) begin
        if (tx_start) begin
          d = rand_mode ? int'($urandom_range(0, BUSY_TIMEOUT + 1)) : cfg_delay;
          l = rand_mode ? int'($urandom_range(1, 6)) : cfg_len;
          cnt = d;
          ph  = 1;
          if (cnt == 0) begin
            tx_busy = 1'b1;
            cnt     = l;
            ph      = 2;
          end
        end
      end else if (ph == 1) begin
        if (!tx_start) begin
          ph = 0;
        end else begin
          cnt--;
          if (cnt == 0) begin
            tx_busy = 1'b1;
            cnt     = l;
            ph      = 2;
          end
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          tx_busy = 1'b0;
          ph      = 0;
        end
      end
    end
  end

  task automatic wait_ready(input string tag, output int who);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req0_ready || req1_ready) && n < 200);
    if (!(req0_ready || req1_ready)) check({tag, "_ready_wait"}, 32'(req0_ready | req1_ready), 32'd1);
    who = req1_ready ? 1 : 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (arb_busy && n < 200);
    if (arb_busy) check({tag, "_idle_wait"}, 32'(arb_busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    int who, n_start, n;
    int order_exp[4] = '{0, 1, 0, 1};
    int wrap_exp[5]  = '{1, 2, 3, 0, 1};

    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_tx_pi",    32'(tx_pi),    32'd0);
    check("rst_sent",     32'({sent1_cnt, sent0_cnt}), 32'd0);
    rst = 1'b0;

    // single req0 frame
    cfg_delay  = 3;
    cfg_len    = 4;
    req0_valid = 1'b1;
    req0_data  = 8'hAC;
    wait_ready("t1", who);
    req0_valid = 1'b0;
    req0_data  = 8'h11;
    check("t1_who",      32'(who),      32'd0);
    check("t1_tx_pi",    32'(tx_pi),    32'hAC);
    check("t1_tx_start", 32'(tx_start), 32'd1);
    wait_idle("t1");
    check("t1_sent0", 32'(sent0_cnt), 32'd1);
    check("t1_grant", 32'(grant),     32'd0);

    // both held from reset: strict alternation starting with req0
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'hAC;
    req1_valid = 1'b1;
    req1_data  = 8'hDC;
    for (int i = 0; i < 4; i++) begin
      wait_ready("t2", who);
      check("t2_order", 32'(who), 32'(order_exp[i]));
      check("t2_data",  32'(tx_pi), (order_exp[i] == 1) ? 32'hDC : 32'hAC);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("t2");

    // req1 alone, three frames
    do_reset();
    req1_valid = 1'b1;
    req1_data  = 8'hDC;
    for (int i = 0; i < 3; i++) begin
      wait_ready("t3", who);
      check("t3_who", 32'(who), 32'd1);
    end
    req1_valid = 1'b0;
    wait_idle("t3");
    check("t3_sent1", 32'(sent1_cnt), 32'd3);

    // transmitter never goes busy
    cfg_delay  = 1000;
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    wait_ready("t4", who);
    req0_valid = 1'b0;
    n_start = 0;
    n = 0;
    while (!timeout_err && n < 100) begin
      if (tx_start) n_start++;
      @(negedge clk);
      n++;
    end
    check("t4_timeout_seen",   32'(timeout_err), 32'd1);
    check("t4_start_cycles",   32'(n_start),     32'(BUSY_TIMEOUT));
    check("t4_sent0_unchanged", 32'(sent0_cnt),  32'd0);
    cfg_delay  = 2;
    req1_valid = 1'b1;
    req1_data  = 8'h5A;
    wait_ready("t4b", who);
    req1_valid = 1'b0;
    check("t4_next_who", 32'(who), 32'd1);
    wait_idle("t4b");
    check("t4_sent1", 32'(sent1_cnt), 32'((3 + 1) % (1 << CNT_W)));

    // counter wrap with CNT_W=2
    do_reset();
    cfg_delay = 1;
    cfg_len   = 2;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req0_data  = 8'(i + 8'h40);
      wait_ready("t6", who);
      req0_valid = 1'b0;
      wait_idle("t6");
      check("t6_wrap", 32'(sent0_cnt), 32'(wrap_exp[i]));
    end

    // asynchronous reset while BUSY
    cfg_delay  = 1;
    cfg_len    = 30;
    req1_valid = 1'b1;
    req1_data  = 8'hE7;
    wait_ready("t5", who);
    req1_valid = 1'b0;
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("t5_pre_arb_busy", 32'(arb_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_tx_start", 32'(tx_start),  32'd0);
    check("t5_arb_busy", 32'(arb_busy),  32'd0);
    check("t5_sent0",    32'(sent0_cnt), 32'd0);
    check("t5_tx_pi",    32'(tx_pi),     32'd0);
    check("t5_grant",    32'(grant),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // random traffic
    rand_mode = 1'b1;
    repeat (600) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("rand");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
